debounce_edge: RTL and testbench
================================

# debounce_edge

Input-conditioning stage that sits directly upstream of the team's storage flops. It takes a raw asynchronous or bouncy single-bit input (button, strap, external flag) and brings it into the `clk` domain through a two-flop synchronizer. It then requires the new level to be stable for a programmable number of cycles before committing it. It drives a clean registered level plus single-cycle rise and fall pulses, which downstream flops use directly as their `d` or enable inputs.

## Interface
- `STABLE_CYCLES`, default 4: consecutive synchronized samples at the new level required to commit. Legal range is 2..65535.
- `RESET_LEVEL`, default 1'b0: value of the synchronizer flops and of `level` during and after reset.
- `clk`  in  1  rising-edge clock. This is the only clock.
- `rst`  in  1  reset, synchronous, active-high.
- `din`  in  1  raw input. It can be asynchronous to `clk`.
- `level`  out  1  debounced level, registered.
- `rise`  out  1  one-cycle pulse, asserted in the same cycle `level` goes 0→1.
- `fall`  out  1  one-cycle pulse, asserted in the same cycle `level` goes 1→0.
- `glitches`  out  8  saturating count of aborted level changes.

## Operation
- **Synchronizer.**
  - `s1 <= din`, `s2 <= s1`.
  - The FSM sees only `s2`.
- **FSM states:** `ST_LOW`, `CHK_HIGH`, `ST_HIGH`, `CHK_LOW`.
- **`ST_LOW`.**
  - `s2 = 1` → go to `CHK_HIGH`, `cnt <= 1`.
  - Otherwise hold.
- **`CHK_HIGH`.**
  - `s2 = 0` → go to `ST_LOW`, `cnt <= 0`, `glitches` +1 (saturates at 255).
  - `s2 = 1` and `cnt == STABLE_CYCLES-1` → go to `ST_HIGH`, `level <= 1`, `rise <= 1`, `cnt <= 0`.
  - Otherwise `cnt <= cnt + 1`.
- **`ST_HIGH` / `CHK_LOW`:** mirror image of the two states above, using `fall`.
- **Counter.** `cnt` width is `$clog2(STABLE_CYCLES)`, with a minimum of 1. It never wraps, because commit or abort always happens at or before `STABLE_CYCLES-1`.
- **Pulses.**
  - `rise` and `fall` are default-0 registers, high for exactly one cycle per commit.
  - They are never high together.
  - Neither is ever high outside a commit.
- **Glitch counter.**
  - `glitches` increments once per abort, in either direction.
  - It holds at 255 and does not wrap.
  - It is cleared only by `rst`.
- **Reset.** While `rst` is high at a rising edge:
  - `s1`, `s2`, `level` ← `RESET_LEVEL`
  - state ← `ST_LOW`, or `ST_HIGH` when `RESET_LEVEL` = 1
  - `cnt`, `rise`, `fall`, `glitches` ← 0
- **Reset mid-check.** An in-progress check is discarded. No pulse and no glitch count are produced for it.

## Timing
- **Commit latency.** `din` settles before edge E0 and stays there. Then:
  - `s2` updates at E1.
  - The FSM takes its first sample at E2.
  - The commit edge is E(STABLE_CYCLES+1), at which `level`, `rise` and `fall` update.
  - Total: `STABLE_CYCLES+2` edges. With the default of 4, `level` changes after E5.
- **Rejected pulses.** A `din` pulse shorter than `STABLE_CYCLES` cycles never changes `level`. One that spans at least one `clk` sample produces exactly one `glitches` increment.
- **Reversal during a check.** The abort takes effect at the edge that samples the reversed `s2`. The opposite check can start only from the stable state, on a later edge.
- **Reset release.** Reset is synchronous, so `rst` deasserting has no combinational effect. The first post-reset sample of `din` into `s1` happens at the first edge with `rst` low.

## Structure
- **`debounce_pkg`.**
  - State encoding localparams `ST_LOW=2'd0`, `CHK_HIGH=2'd1`, `ST_HIGH=2'd2`, `CHK_LOW=2'd3`.
  - The `GLITCH_W = 8` constant.
- **Sub-module `sync_2ff`.**
  - Parameter `RESET_LEVEL`.
  - Ports `clk`, `rst`, `d`, `q`.
  - Reusable for other asynchronous inputs.
- **Top level.** `debounce_edge` instantiates `sync_2ff` and contains the FSM, counter and output registers. All outputs are driven directly from flops.

## Test plan
All scenarios use `STABLE_CYCLES=4`, `RESET_LEVEL=0`.
- **Reset and first rise.** `rst=1` for 2 edges with `din=1`, then `rst=0` while holding `din=1` → during reset `level=0`, `rise=fall=0`, `glitches=0`. After the 6th edge with `rst` low, `level=1` and `rise=1` for exactly one cycle.
- **Short glitch.** From `level=0`, `din=1` for 3 cycles then 0 → `level` stays 0, no `rise`, `glitches=1`.
- **Clean fall.** From `level=1`, `din=0` held → `level=0` and `fall=1` for one cycle on the 6th edge. `glitches` unchanged.
- **Bounce train.** `din` toggles every cycle for 20 cycles, then holds 1 → exactly one `rise` pulse. `level` ends at 1. `glitches` > 0 and ≤ 10.
- **Saturation.** 300 separate 2-cycle high glitches → `glitches=255`, `level=0` throughout.
- **Reset mid-check.** `din=1`, assert `rst` on the 4th edge → `level=0` and no `rise`. After release with `din=1`, the full 6-edge latency is observed again.

Source files
------------

// File: rtl/debounce_edge_pkg.sv
// Shared types and constants for the debounce_edge input-conditioning stage.
package debounce_pkg;

  localparam int unsigned GLITCH_W = 8;

  typedef enum logic [1:0] {
    ST_LOW   = 2'd0,
    CHK_HIGH = 2'd1,
    ST_HIGH  = 2'd2,
    CHK_LOW  = 2'd3
  } state_e;

  // Holds at all-ones instead of wrapping.
  function automatic logic [GLITCH_W-1:0] sat_inc(input logic [GLITCH_W-1:0] v);
    return (v == '1) ? v : v + GLITCH_W'(1);
  endfunction

endpackage

// File: rtl/debounce_edge_if.sv
// Raw input and conditioned outputs of debounce_edge; slave is the debouncer side.
interface debounce_edge_if;
  import debounce_pkg::*;

  logic                din;
  logic                level;
  logic                rise;
  logic                fall;
  logic [GLITCH_W-1:0] glitches;

  modport master (output din, input level, input rise, input fall, input glitches);
  modport slave  (input din, output level, output rise, output fall, output glitches);
endinterface

// File: rtl/debounce_edge_sync_2ff.sv
// Two-flop synchronizer with selectable reset level, for any asynchronous single-bit input.
module sync_2ff #(
  parameter logic RESET_LEVEL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic s1_q, s2_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= RESET_LEVEL;
      s2_q <= RESET_LEVEL;
    end else begin
      s1_q <= d;
      s2_q <= s1_q;
    end
  end

  assign q = s2_q;

endmodule

// File: rtl/debounce_edge.sv
// Synchronizes a bouncy input and commits a new level only after STABLE_CYCLES matching samples.
module debounce_edge
  import debounce_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter logic        RESET_LEVEL   = 1'b0
) (
  input logic            clk,
  input logic            rst,
  debounce_edge_if.slave bus
);

  localparam int unsigned     CntW    = (STABLE_CYCLES > 2) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(STABLE_CYCLES - 1);
  localparam state_e          StReset = RESET_LEVEL ? ST_HIGH : ST_LOW;

  logic s2;

  sync_2ff #(
    .RESET_LEVEL(RESET_LEVEL)
  ) u_sync (
    .clk(clk),
    .rst(rst),
    .d  (bus.din),
    .q  (s2)
  );

  state_e              state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic                level_q, level_d;
  logic                rise_q, rise_d;
  logic                fall_q, fall_d;
  logic [GLITCH_W-1:0] glitch_q, glitch_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StReset;
      cnt_q    <= '0;
      level_q  <= RESET_LEVEL;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
      glitch_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      level_q  <= level_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      glitch_q <= glitch_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    level_d  = level_q;
    rise_d   = 1'b0;
    fall_d   = 1'b0;
    glitch_d = glitch_q;
    unique case (state_q)
      ST_LOW: begin
        if (s2) begin
          state_d = CHK_HIGH;
          cnt_d   = CntW'(1);
        end
      end
      CHK_HIGH: begin
        if (!s2) begin
          state_d  = ST_LOW;
          cnt_d    = '0;
          glitch_d = sat_inc(glitch_q);
        end else if (cnt_q == CntLast) begin
          state_d = ST_HIGH;
          cnt_d   = '0;
          level_d = 1'b1;
          rise_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      ST_HIGH: begin
        if (!s2) begin
          state_d = CHK_LOW;
          cnt_d   = CntW'(1);
        end
      end
      CHK_LOW: begin
        if (s2) begin
          state_d  = ST_HIGH;
          cnt_d    = '0;
          glitch_d = sat_inc(glitch_q);
        end else if (cnt_q == CntLast) begin
          state_d = ST_LOW;
          cnt_d   = '0;
          level_d = 1'b0;
          fall_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: state_d = StReset;
    endcase
  end

  assign bus.level    = level_q;
  assign bus.rise     = rise_q;
  assign bus.fall     = fall_q;
  assign bus.glitches = glitch_q;

endmodule

// File: tb/tb_debounce_edge.sv
// Randomized and directed bench for debounce_edge against a run-length reference model.
module tb_debounce_edge;
  import debounce_pkg::*;

  localparam int unsigned StableCycles = 4;

  logic clk = 1'b0;
  logic rst;

  debounce_edge_if bus ();

  debounce_edge #(
    .STABLE_CYCLES(StableCycles),
    .RESET_LEVEL  (1'b0)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference: din reaches the decision point two edges late; a level flips after
  // StableCycles consecutive differing samples, and any interrupted run is a glitch.
  logic m_s1 = 1'b0, m_s2 = 1'b0, m_level = 1'b0, m_rise = 1'b0, m_fall = 1'b0;
  int   m_run = 0, m_glitch = 0;
  int   rises = 0, falls = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_edge(input logic d, input logic r);
    logic smp;
    smp = m_s2;
    if (r) begin
      m_s1 = 1'b0; m_s2 = 1'b0; m_level = 1'b0;
      m_rise = 1'b0; m_fall = 1'b0; m_run = 0; m_glitch = 0;
    end else begin
      m_rise = 1'b0;
      m_fall = 1'b0;
      if (smp != m_level) begin
        m_run++;
        if (m_run == int'(StableCycles)) begin
          m_level = smp;
          m_rise  = smp;
          m_fall  = !smp;
          m_run   = 0;
        end
      end else if (m_run > 0) begin
        m_glitch = (m_glitch >= 255) ? 255 : m_glitch + 1;
        m_run    = 0;
      end
      m_s2 = m_s1;
      m_s1 = d;
    end
  endtask

  task automatic tick(input logic d, input logic r);
    bus.din = d;
    rst     = r;
    @(posedge clk);
    model_edge(d, r);
    #1;
    check_eq("level", 32'(bus.level), 32'(m_level));
    check_eq("rise", 32'(bus.rise), 32'(m_rise));
    check_eq("fall", 32'(bus.fall), 32'(m_fall));
    check_eq("glitches", 32'(bus.glitches), 32'(m_glitch));
    check_eq("pulse_excl", 32'(bus.rise & bus.fall), 32'd0);
    if (bus.rise === 1'b1) rises++;
    if (bus.fall === 1'b1) falls++;
  endtask

  task automatic edges_to_level(input logic d, input logic target, output int n);
    n = 0;
    do begin
      tick(d, 1'b0);
      n++;
    end while (bus.level !== target && n < 20);
  endtask

  task automatic reset_low();
    tick(1'b0, 1'b1);
    tick(1'b0, 1'b1);
    repeat (3) tick(1'b0, 1'b0);
  endtask

  initial begin
    int n, r0, g;
    logic lvl, went_high;
    bus.din = 1'b0;
    rst     = 1'b1;

    // Reset with din high, then first rise
    tick(1'b1, 1'b1);
    tick(1'b1, 1'b1);
    check_eq("rst_level", 32'(bus.level), 32'd0);
    check_eq("rst_pulses", 32'(bus.rise | bus.fall), 32'd0);
    check_eq("rst_glitches", 32'(bus.glitches), 32'd0);
    for (int i = 1; i <= 6; i++) begin
      tick(1'b1, 1'b0);
      if (i == 5) check_eq("first_rise_early", 32'(bus.level), 32'd0);
    end
    check_eq("first_rise_level", 32'(bus.level), 32'd1);
    check_eq("first_rise_pulse", 32'(bus.rise), 32'd1);
    tick(1'b1, 1'b0);
    check_eq("first_rise_one_cycle", 32'(bus.rise), 32'd0);

    // Clean fall
    edges_to_level(1'b0, 1'b0, n);
    check_eq("fall_latency", 32'(n), 32'd6);
    check_eq("fall_pulse", 32'(bus.fall), 32'd1);
    check_eq("fall_glitches", 32'(bus.glitches), 32'd0);
    tick(1'b0, 1'b0);
    check_eq("fall_one_cycle", 32'(bus.fall), 32'd0);

    // Short glitch
    r0 = rises;
    repeat (3) tick(1'b1, 1'b0);
    repeat (6) tick(1'b0, 1'b0);
    check_eq("short_level", 32'(bus.level), 32'd0);
    check_eq("short_no_rise", 32'(rises - r0), 32'd0);
    check_eq("short_glitches", 32'(bus.glitches), 32'd1);

    // Bounce train
    reset_low();
    r0 = rises;
    for (int i = 0; i < 20; i++) tick((i % 2) == 0, 1'b0);
    repeat (12) tick(1'b1, 1'b0);
    g = int'(bus.glitches);
    check_eq("bounce_rises", 32'(rises - r0), 32'd1);
    check_eq("bounce_level", 32'(bus.level), 32'd1);
    check_eq("bounce_glitch_range", 32'(g > 0 && g <= 10), 32'd1);

    // Reset mid-check
    reset_low();
    r0 = rises;
    repeat (3) tick(1'b1, 1'b0);
    tick(1'b1, 1'b1);
    check_eq("midrst_level", 32'(bus.level), 32'd0);
    check_eq("midrst_glitches", 32'(bus.glitches), 32'd0);
    edges_to_level(1'b1, 1'b1, n);
    check_eq("midrst_latency", 32'(n), 32'd6);
    check_eq("midrst_rises", 32'(rises - r0), 32'd1);

    // Saturation
    reset_low();
    went_high = 1'b0;
    for (int i = 0; i < 300; i++) begin
      tick(1'b1, 1'b0);
      if (bus.level !== 1'b0) went_high = 1'b1;
      tick(1'b1, 1'b0);
      if (bus.level !== 1'b0) went_high = 1'b1;
      repeat (3) tick(1'b0, 1'b0);
    end
    check_eq("sat_glitches", 32'(bus.glitches), 32'd255);
    check_eq("sat_level_low", 32'(went_high), 32'd0);

    // Random segments with occasional resets
    for (int s = 0; s < 300; s++) begin
      lvl = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 49) == 0) tick(lvl, 1'b1);
      n = int'($urandom_range(1, 8));
      repeat (n) tick(lvl, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
